line_buffer_kxk: RTL

//  Parametrised KxK sliding-window generator for the CNN front end; successor of the fixed 3x3 buffer.

---
 rtl/line_buffer_kxk_if.sv | 43 ++++
 rtl/line_buffer_kxk.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_buffer_kxk_if.sv
// Pixel-stream in / window-stream out bundle for line_buffer_kxk.
// Optional feature macro: LBUF_COORD_EN adds the o_row/o_col window coordinates.
interface line_buffer_kxk_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int K_DIM  = 3,
    parameter int MAX_W  = 32,
    parameter int MAX_H  = 32
);
    // i_en is a pure strobe with no back-pressure: a pixel is taken on every rising edge
    // where i_en=1. o_valid is a one-cycle pulse with no ready; the sink must take it.
    logic                              i_en;
    logic                              i_sof;
    logic [$clog2(MAX_W+1)-1:0]        i_img_w;
    logic [$clog2(MAX_H+1)-1:0]        i_img_h;
    logic [CH*DATA_W-1:0]              i_data;
    logic [K_DIM*K_DIM*CH*DATA_W-1:0]  o_win_flat;
    logic                              o_valid;
    logic                              o_last;
    logic                              o_cfg_err;
`ifdef LBUF_COORD_EN
    logic [$clog2(MAX_H)-1:0]          o_row;
    logic [$clog2(MAX_W)-1:0]          o_col;

    modport master (
        output i_en, i_sof, i_img_w, i_img_h, i_data,
        input  o_win_flat, o_valid, o_last, o_cfg_err, o_row, o_col
    );
    modport slave (
        input  i_en, i_sof, i_img_w, i_img_h, i_data,
        output o_win_flat, o_valid, o_last, o_cfg_err, o_row, o_col
    );
`else
    modport master (
        output i_en, i_sof, i_img_w, i_img_h, i_data,
        input  o_win_flat, o_valid, o_last, o_cfg_err
    );
    modport slave (
        input  i_en, i_sof, i_img_w, i_img_h, i_data,
        output o_win_flat, o_valid, o_last, o_cfg_err
    );
`endif
endinterface

// File: rtl/line_buffer_kxk.sv
// KxK sliding-window generator over a raster pixel stream, K-1 line memories of depth MAX_W.
// Optional feature macro: LBUF_COORD_EN registers the top-left coordinate of each emitted window.
module line_buffer_kxk #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int K_DIM  = 3,
    parameter int MAX_W  = 32,
    parameter int MAX_H  = 32,
    parameter int STRIDE = 1
) (
    input logic              clk,
    input logic              rst_n,
    line_buffer_kxk_if.slave bus
);
    localparam int PIX_W = CH * DATA_W;
    localparam int WIN_W = K_DIM * K_DIM * PIX_W;
    localparam int WW    = $clog2(MAX_W + 1);
    localparam int HW    = $clog2(MAX_H + 1);
    localparam int CW    = $clog2(MAX_W);
    localparam int RW    = $clog2(MAX_H);
    localparam int NL    = K_DIM - 1;

    typedef logic [PIX_W-1:0] pix_t;

    logic [CW-1:0]    col_q, col_d, pos_col;
    logic [RW-1:0]    row_q, row_d, pos_row;
    logic [WW-1:0]    w_q, w_cur;
    logic [HW-1:0]    h_q, h_cur;
    logic             cfg_err_q, err_new, err_cur;
    logic             origin, emit, at_last;
    pix_t             win_q  [K_DIM][K_DIM];
    pix_t             win_d  [K_DIM][K_DIM];
    pix_t             lmem_q [NL][MAX_W];
    logic [WIN_W-1:0] win_flat_d, win_flat_q;
    logic             valid_q, last_q;
`ifdef LBUF_COORD_EN
    logic [RW-1:0]    o_row_q;
    logic [CW-1:0]    o_col_q;
`endif

    // Position of the pixel on the bus: (0,0) on i_sof or after a frame wrap / reset.
    always_comb begin
        origin  = bus.i_sof || (col_q == '0 && row_q == '0);
        err_new = (int'(bus.i_img_w) < K_DIM) || (int'(bus.i_img_w) > MAX_W) ||
                  (int'(bus.i_img_h) < K_DIM) || (int'(bus.i_img_h) > MAX_H);
        if (origin) begin
            w_cur   = err_new ? WW'(MAX_W) : bus.i_img_w;
            h_cur   = err_new ? HW'(MAX_H) : bus.i_img_h;
            err_cur = err_new;
            pos_col = '0;
            pos_row = '0;
        end else begin
            w_cur   = w_q;
            h_cur   = h_q;
            err_cur = cfg_err_q;
            pos_col = col_q;
            pos_row = row_q;
        end
    end

    always_comb begin
        col_d = pos_col;
        row_d = pos_row;
        if (int'(pos_col) == int'(w_cur) - 1) begin
            col_d = '0;
            row_d = (int'(pos_row) == int'(h_cur) - 1) ? '0 : pos_row + RW'(1);
        end else begin
            col_d = pos_col + CW'(1);
        end
    end

    // Rows younger than K-1 would expose line-memory contents from an earlier frame.
    always_comb begin
        emit    = bus.i_en && !err_cur &&
                  (int'(pos_row) >= NL) && (int'(pos_col) >= NL) &&
                  (((int'(pos_row) - NL) % STRIDE) == 0) &&
                  (((int'(pos_col) - NL) % STRIDE) == 0);
        at_last = (int'(pos_row) == int'(h_cur) - 1) && (int'(pos_col) == int'(w_cur) - 1);
    end

    // Window shifts left; the new right column is the K-1 stored rows plus the live pixel.
    always_comb begin
        for (int r = 0; r < K_DIM; r++) begin
            for (int c = 0; c < K_DIM - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < NL; r++) begin
            win_d[r][K_DIM-1] = lmem_q[r][pos_col];
        end
        win_d[NL][K_DIM-1] = bus.i_data;
    end

    always_comb begin
        win_flat_d = '0;
        for (int r = 0; r < K_DIM; r++) begin
            for (int c = 0; c < K_DIM; c++) begin
                win_flat_d[(r*K_DIM+c)*PIX_W +: PIX_W] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            cfg_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            win_flat_q <= '0;
            for (int r = 0; r < K_DIM; r++) begin
                for (int c = 0; c < K_DIM; c++) begin
                    win_q[r][c] <= '0;
                end
            end
`ifdef LBUF_COORD_EN
            o_row_q    <= '0;
            o_col_q    <= '0;
`endif
        end else begin
            valid_q <= emit;
            last_q  <= emit && at_last;
            if (bus.i_en) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < K_DIM; r++) begin
                    for (int c = 0; c < K_DIM; c++) begin
                        win_q[r][c] <= win_d[r][c];
                    end
                end
                if (origin) begin
                    w_q       <= w_cur;
                    h_q       <= h_cur;
                    cfg_err_q <= err_cur;
                end
                if (emit) begin
                    win_flat_q <= win_flat_d;
`ifdef LBUF_COORD_EN
                    o_row_q    <= pos_row - RW'(NL);
                    o_col_q    <= pos_col - CW'(NL);
`endif
                end
            end
        end
    end

    // Line memory r=0 holds the oldest row; each accepted pixel pushes its column down by one row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NL; r++) begin
                for (int a = 0; a < MAX_W; a++) begin
                    lmem_q[r][a] <= '0;
                end
            end
        end else if (bus.i_en) begin
            for (int r = 0; r < NL - 1; r++) begin
                lmem_q[r][pos_col] <= lmem_q[r+1][pos_col];
            end
            lmem_q[NL-1][pos_col] <= bus.i_data;
        end
    end

    assign bus.o_win_flat = win_flat_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;
    assign bus.o_cfg_err  = cfg_err_q;
`ifdef LBUF_COORD_EN
    assign bus.o_row      = o_row_q;
    assign bus.o_col      = o_col_q;
`endif
endmodule
